// File: rtl/slink_crc_tx_sequencer.sv
// slink_crc_tx_sequencer: forwards long-packet payload beats and appends the CRC-16/MCRF4XX, low byte first.
module slink_crc_8_16bit_compute #(
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic        init,
  input  logic [1:0]  valid,
  input  logic [15:0] data,
  input  logic [15:0] crc_prev,
  output logic [15:0] crc
);
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'h8408 : r >> 1;
    return r;
  endfunction
  always_comb
    crc = init ? INIT
        : !valid[0] ? crc_prev
        : valid[1] ? crc_byte(crc_byte(crc_prev, data[7:0]), data[15:8])
        : crc_byte(crc_prev, data[7:0]);
endmodule

module slink_crc_tx_sequencer #(
  parameter int          WC_W     = 16,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pkt_start,
  input  logic [WC_W-1:0] pkt_wc,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  output logic [1:0]      out_bytes,
  output logic            out_last,
  output logic            busy,
  output logic            start_err
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PAYLOAD = 3'd1;
  localparam logic [2:0] CRC_W   = 3'd2;
  localparam logic [2:0] CRC_HI  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [WC_W-1:0] rem_q, rem_d;
  logic [15:0]     crc_q, crc_next, out_data_q, out_data_d;
  logic [1:0]      out_bytes_q, out_bytes_d, crc_valid;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic            busy_q, busy_d, start_err_q, start_err_d;
  logic            crc_init, take, free, xfer;

  assign free      = !out_valid_q || out_ready;
  assign xfer      = out_valid_q && out_ready;
  assign in_ready  = (state_q == PAYLOAD) && free;
  assign take      = in_valid && in_ready;
  // An odd tail carries only its low byte into the CRC
  assign crc_valid = (state_q == PAYLOAD && take) ? (rem_q == WC_W'(1) ? 2'b01 : 2'b11) : 2'b00;
  assign crc_init  = (state_q == IDLE && pkt_start) || (state_q == DONE && xfer);

  slink_crc_8_16bit_compute #(.INIT(CRC_INIT)) u_crc (
    .init     (crc_init),
    .valid    (crc_valid),
    .data     (in_data),
    .crc_prev (crc_q),
    .crc      (crc_next)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    start_err_d = pkt_start && state_q != IDLE;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_valid_q && !out_ready && out_last_q;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    case (state_q)
      IDLE: if (pkt_start) begin
        busy_d  = 1'b1;
        rem_d   = pkt_wc;
        state_d = pkt_wc == '0 ? CRC_W : PAYLOAD;
      end
      PAYLOAD: if (take) begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        out_bytes_d = 2'b11;
        out_data_d  = rem_q == WC_W'(1) ? {crc_next[7:0], in_data[7:0]} : in_data;
        rem_d       = rem_q == WC_W'(1) ? '0 : rem_q - WC_W'(2);
        state_d     = rem_q == WC_W'(1) ? CRC_HI : rem_q == WC_W'(2) ? CRC_W : PAYLOAD;
      end
      CRC_W, CRC_HI: if (free) begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_bytes_d = state_q == CRC_W ? 2'b11 : 2'b01;
        out_data_d  = state_q == CRC_W ? crc_q : {8'h00, crc_q[15:8]};
        state_d     = DONE;
      end
      DONE: if (xfer) begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      crc_q       <= CRC_INIT;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      busy_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      crc_q       <= crc_next;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      busy_q      <= busy_d;
      start_err_q <= start_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign start_err = start_err_q;
endmodule

// File: tb/tb_slink_crc_tx_sequencer.sv
// tb_slink_crc_tx_sequencer: randomized packets checked against a byte-stream CRC model.
module tb_slink_crc_tx_sequencer;
  logic        clk = 1'b0, reset = 1'b1, pkt_start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] pkt_wc = '0, in_data = '0;
  logic        in_ready, out_valid, out_last, busy, start_err;
  logic [15:0] out_data;
  logic [1:0]  out_bytes;

  slink_crc_tx_sequencer dut (
    .clk(clk), .reset(reset), .pkt_start(pkt_start), .pkt_wc(pkt_wc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .out_last(out_last), .busy(busy), .start_err(start_err)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  logic [7:0]  pb[$];
  logic [15:0] od[$];
  logic [1:0]  ob[$];
  logic        ol[$];
  int          ir_seen, err_pulses;
  logic [7:0]  hi_fill = 8'h5A;

  function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (b[k]) begin
      c ^= {8'h00, b[k]};
      repeat (8) c = c[0] ? (c >> 1) ^ 16'h8408 : c >> 1;
    end
    return c;
  endfunction

  // err_mode: 0 none, 1 extra start mid-packet, 2 extra start on the final transfer
  task automatic run_packet(input int rmode, input bit gaps, input int err_mode);
    int wc = pb.size(), nb = (pb.size() + 1) / 2, idx = 0, cyc = 0, n;
    bit done = 0, hold = 0;
    logic [15:0] hold_d, c, ed;
    logic [1:0] hold_b, eb;
    logic [7:0] st[$];
    od.delete(); ob.delete(); ol.delete();
    ir_seen = 0; err_pulses = 0;
    pkt_wc = 16'(wc); pkt_start = 1'b1;
    @(posedge clk); #1;
    pkt_start = 1'b0;
    while (!done && cyc < 3000) begin
      pkt_start = err_mode == 1 && cyc == 3;
      if (pkt_start) pkt_wc = 16'($urandom_range(1, 30));
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      in_valid = idx < nb && (!gaps || $urandom_range(0, 2) != 0);
      in_data = 16'($urandom);
      if (idx < nb) in_data = {(2 * idx + 1 < wc) ? pb[2 * idx + 1] : hi_fill, pb[2 * idx]};
      #1;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_bytes !== hold_b)
          $display("FAIL stall_stable: got v=%b d=%h b=%b want v=1 d=%h b=%b", out_valid, out_data, out_bytes, hold_d, hold_b);
        else passed++;
      end
      if (in_ready === 1'b1) ir_seen++;
      if (start_err === 1'b1) err_pulses++;
      if (out_valid && out_ready) begin
        od.push_back(out_data); ob.push_back(out_bytes); ol.push_back(out_last);
        if (out_last) begin
          done = 1;
          if (err_mode == 2) begin pkt_wc = 16'd4; pkt_start = 1'b1; end
        end
      end
      hold = out_valid && !out_ready;
      hold_d = out_data; hold_b = out_bytes;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    pkt_start = 1'b0; in_valid = 1'b0;
    if (start_err === 1'b1) err_pulses++;
    checks++;
    if (!done) $display("FAIL timeout: got no last beat after %0d cycles, want completion", cyc);
    else passed++;
    st = pb;
    c = model_crc(pb);
    st.push_back(c[7:0]); st.push_back(c[15:8]);
    n = (st.size() + 1) / 2;
    checks++;
    if (od.size() != n) $display("FAIL beat_count: got %0d want %0d (wc=%0d)", od.size(), n, wc);
    else passed++;
    for (int k = 0; k < n && k < od.size(); k++) begin
      ed = (2 * k + 1 < st.size()) ? {st[2 * k + 1], st[2 * k]} : {8'h00, st[2 * k]};
      eb = (2 * k + 1 < st.size()) ? 2'b11 : 2'b01;
      checks++;
      if (od[k] !== ed || ob[k] !== eb || ol[k] !== (k == n - 1))
        $display("FAIL beat[%0d]: got d=%h b=%b l=%b want d=%h b=%b l=%b (wc=%0d)", k, od[k], ob[k], ol[k], ed, eb, k == n - 1, wc);
      else passed++;
    end
  endtask

  task automatic load_vector24();
    logic [15:0] v[12] = '{16'h00FF, 16'h0000, 16'hF01E, 16'hC71E, 16'h824F, 16'hC578,
                           16'hE082, 16'h708C, 16'h3CD2, 16'hE978, 16'h00FF, 16'h0100};
    pb.delete();
    foreach (v[k]) begin pb.push_back(v[k][7:0]); pb.push_back(v[k][15:8]); end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({out_valid, out_last, busy, start_err, in_ready} !== 5'b0 || out_data !== 16'h0 || out_bytes !== 2'b0)
      $display("FAIL reset_state: got v=%b l=%b busy=%b err=%b rdy=%b d=%h b=%b want all 0",
               out_valid, out_last, busy, start_err, in_ready, out_data, out_bytes);
    else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vector24();
    load_vector24();
    run_packet(0, 0, 0);
    checks++;
    if (od.size() < 13 || od[12] !== 16'hE569 || ob[12] !== 2'b11 || ol[12] !== 1'b1)
      $display("FAIL vec24_crc: got %h want e569 last with bytes 11", od.size() > 12 ? od[12] : 16'hxxxx);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL vec24_busy_clear: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_wc0();
    pb.delete();
    run_packet(0, 0, 0);
    checks++;
    if (od.size() != 1 || od[0] !== 16'hFFFF) $display("FAIL wc0_beat: got %0d beats first=%h want 1 beat ffff", od.size(), od.size() > 0 ? od[0] : 16'hxxxx);
    else passed++;
    checks++;
    if (ir_seen != 0) $display("FAIL wc0_in_ready: got %0d ready cycles want 0", ir_seen);
    else passed++;
  endtask

  task automatic test_wc1();
    pb.delete(); pb.push_back(8'h00); hi_fill = 8'hAB;
    run_packet(0, 0, 0);
    checks++;
    if (od.size() != 2 || od[0] !== 16'h8700 || od[1] !== 16'h000F || ob[1] !== 2'b01)
      $display("FAIL wc1_beats: got n=%0d d0=%h d1=%h want 8700 then 000f/01", od.size(), od.size() > 0 ? od[0] : 16'hxxxx, od.size() > 1 ? od[1] : 16'hxxxx);
    else passed++;
    hi_fill = 8'h5A;
  endtask

  task automatic test_stall();
    load_vector24();
    run_packet(1, 1, 0);
    checks++;
    if (od.size() < 13 || od[12] !== 16'hE569) $display("FAIL stall_crc: got %h want e569", od.size() > 12 ? od[12] : 16'hxxxx);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int acc = 0, cyc = 0;
    load_vector24();
    pkt_wc = 16'd24; pkt_start = 1'b1;
    @(posedge clk); #1;
    pkt_start = 1'b0; out_ready = 1'b1;
    while (acc < 5 && cyc < 100) begin
      in_valid = 1'b1;
      in_data = {pb[2 * acc + 1], pb[2 * acc]};
      #1;
      if (in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || acc != 5)
      $display("FAIL reset_mid: got busy=%b v=%b rdy=%b beats=%0d want 0 0 0 5", busy, out_valid, in_ready, acc);
    else passed++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    test_wc0();
  endtask

  task automatic test_start_err();
    load_vector24();
    run_packet(2'($urandom_range(0, 2)), 1, 1);
    checks++;
    if (err_pulses != 1) $display("FAIL start_err_mid: got %0d pulse cycles want 1", err_pulses);
    else passed++;
    load_vector24();
    run_packet(0, 0, 2);
    checks++;
    if (err_pulses != 1) $display("FAIL start_err_final: got %0d pulse cycles want 1", err_pulses);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (start_err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL start_err_after: got err=%b busy=%b v=%b want 0 0 0", start_err, busy, out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 8; p++) begin
      pb.delete();
      repeat ($urandom_range(0, 37)) pb.push_back(8'($urandom));
      hi_fill = 8'($urandom);
      run_packet(2, 1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_vector24();
    test_wc0();
    test_wc1();
    test_stall();
    test_reset_mid();
    test_start_err();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
